pipe_stage_reg: RTL and testbench

- Parametrised pipeline boundary register for the MEM/WB and similar stage boundaries.
- Carries NUM_CH data channels of DATA_W bits each. For MEM/WB: read data, ALU result and write data, so NUM_CH=3 and DATA_W=16.
- Adds a valid/ready handshake, back-pressure via an optional one-entry skid buffer, and a synchronous flush for hazard squashing.
- Sits between any two pipeline stages and replaces fixed always-enabled 16-bit stage registers.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_entry.sv | 28 ++
 rtl/pipe_stage_reg.sv | 102 ++++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline boundary register.
package pipe_pkg;

  localparam int OCC_W = 2;

  // Total bundle width for a given channel count and channel width.
  function automatic int bw(input int num_ch, input int data_w);
    return num_ch * data_w;
  endfunction

  // Lowest bit index of channel k inside a bundle.
  function automatic int ch_lo(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot: a valid flag plus a bundle register.
// load writes data and marks it valid; clr drops the valid flag but keeps data.
module pipe_entry #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  // Valid flag: reset > load > clear.
  always_ff @(posedge clk) begin
    if (rst)       valid_q <= 1'b0;
    else if (load) valid_q <= 1'b1;
    else if (clr)  valid_q <= 1'b0;
  end

  // Data register: only reset or load touch it, so a cleared slot keeps its last value.
  always_ff @(posedge clk) begin
    if (rst)       data_q <= '0;
    else if (load) data_q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, optional skid slot
// and synchronous flush. Entry M drives the output; entry S (SKID=1 only)
// absorbs one bundle so in_ready can be taken from a register.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 3,
  parameter bit SKID   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [1:0]               occ
);

  localparam int BW = bw(NUM_CH, DATA_W);

  logic             m_valid, s_valid;
  logic [BW-1:0]    m_data, s_data;
  logic             in_fire, out_fire, m_take;
  logic             m_load, m_clr, s_load, s_clr;
  logic             m_vn, s_vn;
  logic [BW-1:0]    m_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  // With a skid slot, in_ready comes straight from the S valid register and
  // never sees out_ready; without it, a stalled M frees up in the same cycle.
  assign in_ready  = SKID ? ~s_valid : (~m_valid | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid & out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign occ       = occ_q;

  pipe_entry #(.W(BW)) u_m (
    .clk     (clk),
    .rst     (rst),
    .load    (m_load),
    .clr     (m_clr),
    .d       (m_d),
    .valid_q (m_valid),
    .data_q  (m_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_entry #(.W(BW)) u_s (
        .clk     (clk),
        .rst     (rst),
        .load    (s_load),
        .clr     (s_clr),
        .d       (in_data),
        .valid_q (s_valid),
        .data_q  (s_data)
      );
    end else begin : g_noskid
      assign s_valid = 1'b0;
      assign s_data  = '0;
    end
  endgenerate

  // Entry control: M refills from S first to keep FIFO order; flush blocks
  // every load so a bundle offered alongside it is dropped.
  always_comb begin
    m_take = 1'b0;
    m_load = 1'b0;
    m_clr  = 1'b0;
    s_load = 1'b0;
    s_clr  = 1'b0;
    m_d    = in_data;
    if (SKID) begin
      m_take = ~m_valid | out_fire;
      m_load = ~flush & m_take & (s_valid | in_fire);
      m_d    = s_valid ? s_data : in_data;
      m_clr  = flush | (m_take & ~s_valid & ~in_fire);
      s_load = ~flush & in_fire & (s_valid | ~m_take);
      s_clr  = flush | m_take;
    end else begin
      m_take = ~m_valid | out_fire;
      m_load = ~flush & in_fire;
      m_clr  = flush | out_fire;
    end
    m_vn  = m_load | (m_valid & ~m_clr);
    s_vn  = s_load | (s_valid & ~s_clr);
    occ_d = {1'b0, m_vn} + {1'b0, s_vn};
  end

  // Occupancy tracks the next-state valid bits so it lines up with the entries.
  always_ff @(posedge clk) begin
    if (rst)        occ_q <= '0;
    else if (flush) occ_q <= '0;
    else            occ_q <= occ_d;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 16;
  localparam int NC = 3;
  localparam int BW = NC * DW;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic [BW-1:0] din;
    logic          ordy;
    logic          chk_rdy;
    logic          rdy;
    logic          ov;
    logic [BW-1:0] od;
    logic [1:0]    occ;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush1, iv1, rdy1, ov1, or1;
  logic [BW-1:0] din1, od1;
  logic [1:0] occ1;
  logic flush0, iv0, rdy0, ov0, or0;
  logic [BW-1:0] din0, od0;
  logic [1:0] occ0;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] outq0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .NUM_CH(NC), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(iv1), .in_ready(rdy1),
    .in_data(din1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .occ(occ1)
  );

  pipe_stage_reg #(.DATA_W(DW), .NUM_CH(NC), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(iv0), .in_ready(rdy0),
    .in_data(din0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .occ(occ0)
  );

  // Log every bundle the SKID=0 instance hands downstream.
  always @(posedge clk) begin
    if (!rst && ov0 === 1'b1 && or0 === 1'b1) outq0.push_back(od0);
  end

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [BW-1:0] din, input logic ordy,
                              input logic chk_rdy, input logic rdy,
                              input logic ov, input logic [BW-1:0] od,
                              input logic [1:0] occ);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = iv; t.din = din; t.ordy = ordy;
    t.chk_rdy = chk_rdy; t.rdy = rdy; t.ov = ov; t.od = od; t.occ = occ;
    return t;
  endfunction

  // Drive one cycle of inputs, check in_ready before the edge, outputs after it.
  task automatic run(input vec_t t, input bit sk, input string tag);
    rst = t.rst;
    if (sk) begin
      flush1 = t.flush; iv1 = t.iv; din1 = t.din; or1 = t.ordy;
    end else begin
      flush0 = t.flush; iv0 = t.iv; din0 = t.din; or0 = t.ordy;
    end
    #1;
    if (t.chk_rdy) chk({tag, ".in_ready"}, BW'(sk ? rdy1 : rdy0), BW'(t.rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, BW'(sk ? ov1 : ov0), BW'(t.ov));
    chk({tag, ".out_data"},  sk ? od1 : od0, t.od);
    chk({tag, ".occ"},       BW'(sk ? occ1 : occ0), BW'(t.occ));
  endtask

  localparam logic [BW-1:0] B0   = {16'h3333, 16'h2222, 16'h1111};
  localparam logic [BW-1:0] JUNK = 48'hDEAD_BEEF_5A5A;
  localparam logic [BW-1:0] A    = 48'h000A;
  localparam logic [BW-1:0] B    = 48'h000B;
  localparam logic [BW-1:0] C    = 48'h000C;
  localparam logic [BW-1:0] D    = 48'h00DD;
  localparam logic [BW-1:0] P    = {16'hA1A1, 16'h0B0B, 16'h0101};
  localparam logic [BW-1:0] Q    = {16'hA2A2, 16'h0C0C, 16'h0202};
  localparam logic [BW-1:0] R    = {16'hA3A3, 16'h0D0D, 16'h0303};

  vec_t tbl1[22];
  vec_t tbl0[6];

  initial begin
    logic [BW-1:0] bun;
    rst = 1'b1;
    flush1 = 0; iv1 = 0; din1 = '0; or1 = 0;
    flush0 = 0; iv0 = 0; din0 = '0; or0 = 1;

    //              rst f  iv din   or chk rdy ov od  occ
    tbl1[0]  = mk(1, 0, 1, JUNK, 1, 0, 0, 0, '0, 0);
    tbl1[1]  = mk(1, 0, 1, JUNK, 1, 1, 1, 0, '0, 0);
    tbl1[2]  = mk(0, 0, 1, B0,   1, 1, 1, 1, B0, 1);
    tbl1[3]  = mk(0, 0, 0, JUNK, 1, 1, 1, 0, B0, 0);
    tbl1[4]  = mk(0, 0, 1, A,    0, 1, 1, 1, A,  1);
    tbl1[5]  = mk(0, 0, 1, B,    0, 1, 1, 1, A,  2);
    tbl1[6]  = mk(0, 0, 1, C,    0, 1, 0, 1, A,  2);
    tbl1[7]  = mk(0, 0, 1, C,    1, 1, 0, 1, B,  1);
    tbl1[8]  = mk(0, 0, 1, C,    1, 1, 1, 1, C,  1);
    tbl1[9]  = mk(0, 0, 0, JUNK, 1, 1, 1, 0, C,  0);
    tbl1[10] = mk(0, 0, 1, A,    0, 1, 1, 1, A,  1);
    tbl1[11] = mk(0, 0, 1, B,    0, 1, 1, 1, A,  2);
    tbl1[12] = mk(0, 1, 1, D,    0, 1, 0, 0, A,  0);
    tbl1[13] = mk(0, 1, 1, D,    1, 1, 1, 0, A,  0);
    tbl1[14] = mk(0, 0, 0, JUNK, 1, 1, 1, 0, A,  0);
    tbl1[15] = mk(0, 0, 1, A,    0, 1, 1, 1, A,  1);
    tbl1[16] = mk(0, 0, 1, B,    0, 1, 1, 1, A,  2);
    tbl1[17] = mk(1, 0, 1, C,    0, 1, 0, 0, '0, 0);
    tbl1[18] = mk(0, 0, 1, A,    0, 1, 1, 1, A,  1);
    tbl1[19] = mk(1, 0, 1, B,    0, 1, 1, 0, '0, 0);
    tbl1[20] = mk(0, 0, 0, JUNK, 1, 1, 1, 0, '0, 0);
    tbl1[21] = mk(0, 0, 0, JUNK, 1, 1, 1, 0, '0, 0);

    tbl0[0]  = mk(0, 0, 1, P,    1, 1, 1, 1, P,  1);
    tbl0[1]  = mk(0, 0, 1, Q,    0, 1, 0, 1, P,  1);
    tbl0[2]  = mk(0, 0, 1, Q,    1, 1, 1, 1, Q,  1);
    tbl0[3]  = mk(0, 0, 1, R,    0, 1, 0, 1, Q,  1);
    tbl0[4]  = mk(0, 0, 1, R,    1, 1, 1, 1, R,  1);
    tbl0[5]  = mk(0, 0, 0, JUNK, 1, 1, 1, 0, R,  0);

    for (int i = 0; i < 22; i++) run(tbl1[i], 1'b1, $sformatf("s1v%0d", i));

    // Streaming: one bundle per cycle, channels carry distinct patterns.
    for (int i = 0; i < 20; i++) begin
      bun = {16'(16'h5000 + i), 16'(~i), 16'(i)};
      iv1 = 1'b1; din1 = bun; or1 = 1'b1;
      #1;
      chk($sformatf("stream%0d.in_ready", i), BW'(rdy1), BW'(1'b1));
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d.out_valid", i), BW'(ov1), BW'(1'b1));
      chk($sformatf("stream%0d.out_data", i), od1, bun);
      chk($sformatf("stream%0d.occ", i), BW'(occ1), BW'(2'd1));
    end
    iv1 = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_end.out_valid", BW'(ov1), BW'(1'b0));
    chk("stream_end.occ", BW'(occ1), BW'(2'd0));

    // SKID=0 stall: in_ready must respond to out_ready within the cycle.
    outq0.delete();
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        rst = 1'b0; iv0 = 1'b1; din0 = Q; or0 = 1'b1;
        #1;
        chk("s0.comb_ready_hi", BW'(rdy0), BW'(1'b1));
        or0 = 1'b0;
        #1;
        chk("s0.comb_ready_lo", BW'(rdy0), BW'(1'b0));
        #1;
      end
      run(tbl0[i], 1'b0, $sformatf("s0v%0d", i));
    end
    chk("s0.out_count", BW'(outq0.size()), BW'(3));
    if (outq0.size() == 3) begin
      chk("s0.out0", outq0[0], P);
      chk("s0.out1", outq0[1], Q);
      chk("s0.out2", outq0[2], R);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
